// File: rtl/spi_peri_bytes.sv
// SPI mode-0 peripheral byte front end: oversamples the bus in clk_i, emits one rx byte
// per 8 SCK bits and shifts out the reply accepted for the previous byte.
module spi_peri_bytes #(
   parameter int SYNC_STAGES = 2
) (
   input  logic       clk_i,
   input  logic       rst_ni,
   input  logic       spi_sck_i,
   input  logic       spi_csn_i,
   input  logic       spi_sdi_i,
   output logic       spi_sdo_o,
   output logic [7:0] rx_data_o,
   output logic       rx_valid_o,
   input  logic [7:0] tx_data_i,
   input  logic       tx_valid_i
);

   logic [SYNC_STAGES-1:0] sck_sync, csn_sync, sdi_sync;
   logic                   sck_d, csn_d;
   logic                   sck_s, csn_s, sdi_s;
   logic                   sck_rise, sck_fall, csn_fall, csn_rise;

   logic [2:0] bit_cnt;
   logic [6:0] rx_shift;
   // Only the bits still to be sent; bit 7 of a reply goes straight to spi_sdo_o at load time.
   logic [6:0] tx_shift;
   logic [7:0] tx_hold;
   logic [7:0] load_val;
   logic       frame_active;
   logic       load_now;

   assign sck_s = sck_sync[SYNC_STAGES-1];
   assign csn_s = csn_sync[SYNC_STAGES-1];
   assign sdi_s = sdi_sync[SYNC_STAGES-1];

   assign sck_rise = sck_s & ~sck_d;
   assign sck_fall = ~sck_s & sck_d;
   assign csn_fall = ~csn_s & csn_d;
   assign csn_rise = csn_s & ~csn_d;

   assign frame_active = ~csn_s;
   assign load_val     = tx_valid_i ? tx_data_i : tx_hold;
   assign load_now     = csn_fall | (frame_active & sck_fall & (bit_cnt == 3'd0));

   // Synchronizers reset to the idle bus so a reset never fabricates an edge.
   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         sck_sync <= '0;
         csn_sync <= '1;
         sdi_sync <= '0;
         sck_d    <= 1'b0;
         csn_d    <= 1'b1;
      end else begin
         // NOTE: non-blocking assignments make every stage sample the previous cycle's value,
         // which is what turns this into a real flop chain instead of a wire.
         sck_sync <= {sck_sync[SYNC_STAGES-2:0], spi_sck_i};
         csn_sync <= {csn_sync[SYNC_STAGES-2:0], spi_csn_i};
         sdi_sync <= {sdi_sync[SYNC_STAGES-2:0], spi_sdi_i};
         sck_d    <= sck_s;
         csn_d    <= csn_s;
      end
   end

   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         bit_cnt    <= 3'd0;
         rx_shift   <= '0;
         tx_shift   <= '0;
         tx_hold    <= 8'h00;
         rx_data_o  <= 8'h00;
         rx_valid_o <= 1'b0;
         spi_sdo_o  <= 1'b0;
      end else begin
         rx_valid_o <= 1'b0;

         // A strobe in a load cycle is consumed directly; otherwise the newest strobe is kept.
         if (load_now)
            tx_hold <= 8'h00;
         else if (tx_valid_i)
            tx_hold <= tx_data_i;

         if (csn_rise) begin
            bit_cnt   <= 3'd0;
            rx_shift  <= '0;
            tx_shift  <= '0;
            spi_sdo_o <= 1'b0;
         end else if (csn_fall) begin
            bit_cnt   <= 3'd0;
            tx_shift  <= load_val[6:0];
            spi_sdo_o <= load_val[7];
         end else if (frame_active) begin
            if (sck_rise) begin
               rx_shift <= {rx_shift[5:0], sdi_s};
               bit_cnt  <= bit_cnt + 3'd1;
               if (bit_cnt == 3'd7) begin
                  rx_data_o  <= {rx_shift, sdi_s};
                  rx_valid_o <= 1'b1;
               end
            end else if (sck_fall) begin
               if (bit_cnt == 3'd0) begin
                  tx_shift  <= load_val[6:0];
                  spi_sdo_o <= load_val[7];
               end else begin
                  tx_shift  <= {tx_shift[5:0], 1'b0};
                  spi_sdo_o <= tx_shift[6];
               end
            end
         end
      end
   end

endmodule

// File: tb/tb_spi_peri_bytes.sv
// Bench for spi_peri_bytes: drives SPI frames at clk/8 with random phase and scoreboards
// rx bytes (checked on rx_valid pulses) and SDO bytes (captured at each SCK rise).
module tb_spi_peri_bytes;

   logic       clk;
   logic       rst_n;
   logic       sck, csn, sdi;
   logic       sdo;
   logic [7:0] rx_data;
   logic       rx_valid;
   logic [7:0] tx_data;
   logic       tx_valid;

   logic       man_valid;
   logic [7:0] man_data;
   logic       auto_en;
   logic [7:0] auto_data;

   int tests_run = 0;
   int fails     = 0;

   logic [7:0] exp_rx_q[$];
   logic [7:0] exp_sdo_q[$];

   // Replies can be strobed by hand or tied combinationally to rx_valid.
   assign tx_valid = man_valid | (auto_en & rx_valid);
   assign tx_data  = man_valid ? man_data : auto_data;

   spi_peri_bytes #(.SYNC_STAGES(2)) dut (
      .clk_i     (clk),
      .rst_ni    (rst_n),
      .spi_sck_i (sck),
      .spi_csn_i (csn),
      .spi_sdi_i (sdi),
      .spi_sdo_o (sdo),
      .rx_data_o (rx_data),
      .rx_valid_o(rx_valid),
      .tx_data_i (tx_data),
      .tx_valid_i(tx_valid)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Every rx pulse must match the oldest expected byte; a pulse with nothing expected is an error.
   always @(negedge clk) begin
      if (rst_n && rx_valid) begin
         tests_run++;
         if (exp_rx_q.size() == 0) begin
            fails++;
            $display("FAIL rx_unexpected: got pulse data=%02h, required no pulse", rx_data);
         end else begin
            logic [7:0] e;
            e = exp_rx_q.pop_front();
            if (rx_data !== e) begin
               fails++;
               $display("FAIL rx_byte: got %02h, required %02h", rx_data, e);
            end
         end
      end
   end

   task automatic spi_bits(input logic [7:0] mosi, input int nbits, input bit chk_sdo);
      logic [7:0] got;
      got = 8'h00;
      if (nbits == 8) exp_rx_q.push_back(mosi);
      for (int i = 0; i < nbits; i++) begin
         sdi = mosi[7-i];
         #40;
         got = {got[6:0], sdo};
         sck = 1'b1;
         #40;
         sck = 1'b0;
      end
      if (chk_sdo) begin
         tests_run++;
         if (exp_sdo_q.size() == 0) begin
            fails++;
            $display("FAIL sdo_byte: got %02h, required nothing queued", got);
         end else begin
            logic [7:0] e;
            e = exp_sdo_q.pop_front();
            if (got !== e) begin
               fails++;
               $display("FAIL sdo_byte: got %02h, required %02h", got, e);
            end
         end
      end
   endtask

   task automatic frame_begin();
      @(negedge clk);
      #($urandom_range(1, 4));
      csn = 1'b0;
      #80;
   endtask

   task automatic frame_end();
      #80;
      csn = 1'b1;
      #100;
   endtask

   task automatic strobe(input logic [7:0] d);
      @(negedge clk);
      man_data  = d;
      man_valid = 1'b1;
      @(negedge clk);
      man_valid = 1'b0;
   endtask

   task automatic check_drained(input string name);
      tests_run++;
      if (exp_rx_q.size() != 0) begin
         fails++;
         $display("FAIL %s_rx_missing: got %0d pulses outstanding, required 0", name, exp_rx_q.size());
         exp_rx_q.delete();
      end
   endtask

   task automatic check_outputs_zero(input string name);
      tests_run++;
      if (rx_valid !== 1'b0 || rx_data !== 8'h00 || sdo !== 1'b0) begin
         fails++;
         $display("FAIL %s: got valid=%b data=%02h sdo=%b, required 0/00/0", name, rx_valid, rx_data, sdo);
      end
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      check_outputs_zero("reset_state");
      rst_n = 1'b1;
      repeat (100) @(negedge clk);
      check_outputs_zero("idle_100");
      check_drained("idle");
   endtask

   task automatic test_stream();
      auto_en   = 1'b1;
      auto_data = 8'h01;
      exp_sdo_q.push_back(8'h00);
      exp_sdo_q.push_back(8'h01);
      exp_sdo_q.push_back(8'h01);
      frame_begin();
      spi_bits(8'h85, 8, 1'b1);
      spi_bits(8'h00, 8, 1'b1);
      spi_bits(8'h00, 8, 1'b1);
      frame_end();
      auto_en = 1'b0;
      check_drained("stream");
   endtask

   task automatic test_reply_once();
      auto_data = 8'hA5;
      exp_sdo_q.push_back(8'h00);
      exp_sdo_q.push_back(8'hA5);
      exp_sdo_q.push_back(8'h00);
      frame_begin();
      auto_en = 1'b1;
      spi_bits(8'h5A, 8, 1'b1);
      auto_en = 1'b0;
      spi_bits(8'hC7, 8, 1'b1);
      spi_bits(8'h18, 8, 1'b1);
      frame_end();
      check_drained("reply_once");
   endtask

   task automatic test_abort();
      frame_begin();
      spi_bits(8'hFF, 5, 1'b0);
      #40;
      csn = 1'b1;
      #100;
      exp_sdo_q.push_back(8'h00);
      frame_begin();
      spi_bits(8'h3C, 8, 1'b1);
      frame_end();
      check_drained("abort");
   endtask

   task automatic test_newest_and_reset();
      strobe(8'h11);
      strobe(8'h22);
      auto_en   = 1'b1;
      auto_data = 8'hFF;
      exp_sdo_q.push_back(8'h22);
      frame_begin();
      spi_bits(8'h5A, 8, 1'b1);
      auto_en = 1'b0;
      spi_bits(8'h00, 3, 1'b0);
      repeat (5) @(negedge clk);
      tests_run++;
      if (sdo !== 1'b1) begin
         fails++;
         $display("FAIL sdo_mid_byte: got %b, required 1", sdo);
      end
      strobe(8'h99);
      @(negedge clk);
      rst_n     = 1'b0;
      man_data  = 8'h44;
      man_valid = 1'b1;
      @(negedge clk);
      man_valid = 1'b0;
      check_outputs_zero("reset_mid_frame");
      csn = 1'b1;
      repeat (5) @(negedge clk);
      rst_n = 1'b1;
      repeat (10) @(negedge clk);
      check_drained("reset_mid_frame");
      exp_sdo_q.push_back(8'h00);
      frame_begin();
      spi_bits(8'hC3, 8, 1'b1);
      frame_end();
      check_drained("after_reset");
   endtask

   task automatic test_back_to_back();
      exp_sdo_q.push_back(8'h00);
      frame_begin();
      spi_bits(8'h81, 8, 1'b1);
      #80;
      strobe(8'h6E);
      csn = 1'b1;
      #100;
      exp_sdo_q.push_back(8'h6E);
      frame_begin();
      spi_bits(8'h42, 8, 1'b1);
      frame_end();
      check_drained("carry_reply");
      for (int f = 0; f < 4; f++) begin
         logic [7:0] b0, b1, d;
         b0 = 8'($urandom_range(0, 255));
         b1 = 8'($urandom_range(0, 255));
         d  = 8'($urandom_range(1, 255));
         auto_data = d;
         auto_en   = 1'b1;
         exp_sdo_q.push_back(8'h00);
         exp_sdo_q.push_back(d);
         frame_begin();
         spi_bits(b0, 8, 1'b1);
         spi_bits(b1, 8, 1'b1);
         frame_end();
         auto_en = 1'b0;
      end
      check_drained("phase_sweep");
   endtask

   initial begin
      rst_n     = 1'b0;
      sck       = 1'b0;
      csn       = 1'b1;
      sdi       = 1'b0;
      man_valid = 1'b0;
      man_data  = 8'h00;
      auto_en   = 1'b0;
      auto_data = 8'h00;
      test_reset();
      test_stream();
      test_reply_once();
      test_abort();
      test_newest_and_reset();
      test_back_to_back();
      repeat (20) @(negedge clk);
      $display("[TB] %0d tests run, %0d failed", tests_run, fails);
      $finish;
   end

endmodule
